// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: primary writeback vs. buffered late results.
// Optional direct M-to-port path when REGWR_BYPASS_EN is defined.
module regwrite_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        p_valid,
  input  logic                        p_regdst,
  input  logic [ADDR_W-1:0]           p_rt,
  input  logic [ADDR_W-1:0]           p_rd,
  input  logic [DATA_W-1:0]           p_data,
  output logic                        p_ready,
  input  logic                        m_valid,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [DATA_W-1:0]           m_data,
  output logic                        m_ready,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        addr_sel,
  output logic [$clog2(DEPTH):0]      pending
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_vld;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;

  logic [ADDR_W-1:0] p_addr;
  logic              conflict;
  logic              force_q;
  logic              empty;
  logic              grant_p;
  logic              grant_q;
  logic              grant_b;
  logic              push;
  logic              pop;

  logic              g_any;
  logic              g_sel;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  assign p_addr  = p_regdst ? p_rd : p_rt;
  assign empty   = (count == '0);
  assign force_q = (wait_cnt == WAIT_W'(STARVE_LIM)) && !empty;

  // WAW guard: P may not overtake an older buffered write to the same reg.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (q_addr[i] == p_addr))
        conflict = 1'b1;
    end
    conflict = conflict && p_valid && (p_addr != '0);
  end

  assign p_ready = !conflict && !force_q;
  assign m_ready = (count != CNT_W'(DEPTH));

  assign grant_p = p_valid && p_ready;
  assign grant_q = !grant_p && !empty;
`ifdef REGWR_BYPASS_EN
  assign grant_b = !grant_p && empty && m_valid;
`else
  assign grant_b = 1'b0;
`endif
  assign push = m_valid && m_ready && !grant_b;
  assign pop  = grant_q;

  always_comb begin
    g_any  = 1'b0;
    g_sel  = 1'b0;
    g_addr = '0;
    g_data = '0;
    unique case (1'b1)
      grant_p: begin
        g_any  = 1'b1;
        g_sel  = p_regdst;
        g_addr = p_addr;
        g_data = p_data;
      end
      grant_q: begin
        g_any  = 1'b1;
        g_addr = q_addr[rd_ptr];
        g_data = q_data[rd_ptr];
      end
      grant_b: begin
        g_any  = 1'b1;
        g_addr = m_addr;
        g_data = m_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= m_addr;
      q_data[wr_ptr] <= m_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_vld  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (empty || pop)
      wait_cnt <= '0;
    else if (wait_cnt != WAIT_W'(STARVE_LIM))
      wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // $0 grants still consume the slot but never assert the enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      addr_sel <= 1'b0;
    end else if (g_any) begin
      wr_en    <= (g_addr != '0);
      wr_addr  <= g_addr;
      wr_data  <= g_data;
      addr_sel <= g_sel;
    end else begin
      wr_en    <= 1'b0;
      addr_sel <= 1'b0;
    end
  end

  assign pending = count;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: vector table, corner sequences, random vs model.
// Honours REGWR_BYPASS_EN the same way as the design.
module tb_regwrite_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;
`ifdef REGWR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p_valid = 1'b0;
  logic          p_regdst = 1'b0;
  logic [AW-1:0] p_rt = '0;
  logic [AW-1:0] p_rd = '0;
  logic [DW-1:0] p_data = '0;
  logic          p_ready;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          addr_sel;
  logic [1:0]    pending;

  int n_cmp = 0;
  int n_err = 0;

  regwrite_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_regdst(p_regdst),
    .p_rt(p_rt), .p_rd(p_rd), .p_data(p_data),
    .p_ready(p_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
    .m_ready(m_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .addr_sel(addr_sel), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic rdst,
                       input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                       input logic [DW-1:0] pd, input logic mv,
                       input logic [AW-1:0] ma, input logic [DW-1:0] md);
    p_valid  = pv;
    p_regdst = rdst;
    p_rt     = rt;
    p_rd     = rd;
    p_data   = pd;
    m_valid  = mv;
    m_addr   = ma;
    m_data   = md;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic          pv;
    logic          rdst;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
    logic          en;
    logic          sel;
    logic          chk_ad;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  vec_t tbl[7];
  ent_t mq[$];

  initial begin
    tbl[0] = '{1, 1,  3,  7, 16'h1234, 1, 1, 1,  7, 16'h1234};
    tbl[1] = '{1, 0,  3,  7, 16'h5678, 1, 0, 1,  3, 16'h5678};
    tbl[2] = '{0, 1,  3,  7, 16'hFFFF, 0, 0, 1,  3, 16'h5678};
    tbl[3] = '{1, 1,  1, 31, 16'hABCD, 1, 1, 1, 31, 16'hABCD};
    tbl[4] = '{1, 1,  9,  0, 16'h9999, 0, 1, 0,  0, 16'h0000};
    tbl[5] = '{1, 0,  0,  4, 16'h1111, 0, 0, 0,  0, 16'h0000};
    tbl[6] = '{1, 0, 17,  0, 16'h2222, 1, 0, 1, 17, 16'h2222};

    // Reset state
    do_reset();
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_addr_sel", addr_sel, 0);
    chk("rst_pending", pending, 0);

    // P-only table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tbl[i].pv, tbl[i].rdst, tbl[i].rt, tbl[i].rd, tbl[i].d, 0, 0, 0);
      #1;
      chk($sformatf("tbl%0d_p_ready", i), p_ready, 1);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].en);
      chk($sformatf("tbl%0d_addr_sel", i), addr_sel, tbl[i].sel);
      if (tbl[i].chk_ad) begin
        chk($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].data);
      end
    end

    // Starvation: M addr 9 waits behind continuous P traffic to addr 5
    do_reset();
    @(negedge clk);
    drive(1, 1, 0, 5, 16'h5555, 1, 9, 16'hBEEF);
    @(negedge clk);
    drive(1, 1, 0, 5, 16'h5555, 0, 0, 0);
    for (int i = 0; i < LIM; i++) begin
      #1;
      chk($sformatf("starve_p_ready%0d", i), p_ready, 1);
      @(posedge clk);
      #1;
      chk($sformatf("starve_p_addr%0d", i), wr_addr, 5);
      @(negedge clk);
    end
    #1;
    chk("starve_force", p_ready, 0);
    @(posedge clk);
    #1;
    chk("starve_m_addr", wr_addr, 9);
    chk("starve_m_data", wr_data, 16'hBEEF);
    chk("starve_m_en", wr_en, 1);
    chk("starve_pending", pending, 0);
    @(negedge clk);
    #1;
    chk("starve_clear", p_ready, 1);
    @(posedge clk);
    #1;
    chk("starve_after", wr_addr, 5);

    // WAW ordering on addr 12
    do_reset();
    @(negedge clk);
    drive(1, 1, 0, 5, 16'h5555, 1, 12, 16'h0AAA);
    @(negedge clk);
    drive(1, 1, 0, 12, 16'h0BBB, 0, 0, 0);
    #1;
    chk("waw_stall", p_ready, 0);
    @(posedge clk);
    #1;
    chk("waw_first_addr", wr_addr, 12);
    chk("waw_first_data", wr_data, 16'h0AAA);
    @(negedge clk);
    #1;
    chk("waw_release", p_ready, 1);
    @(posedge clk);
    #1;
    chk("waw_second_data", wr_data, 16'h0BBB);
    chk("waw_second_en", wr_en, 1);

    // Full FIFO with P busy, then async reset mid-burst
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 1, 0, 5, 16'h5555, 1, AW'(i + 1), 16'(i));
      #1;
      chk($sformatf("full_m_ready%0d", i), m_ready, (i < 2) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("full_pending", pending, 2);
    chk("full_wr_addr", wr_addr, 5);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pending", pending, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_addr_sel", addr_sel, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("arst_stale_en%0d", i), wr_en, 0);
      chk($sformatf("arst_stale_pend%0d", i), pending, 0);
    end

    // $0 destination is consumed without a write
    @(negedge clk);
    drive(1, 0, 0, 9, 16'h7777, 0, 0, 0);
    #1;
    chk("zero_p_ready", p_ready, 1);
    @(posedge clk);
    #1;
    chk("zero_wr_en", wr_en, 0);
    chk("zero_pending", pending, 0);

    // Lone M request into an empty arbiter
    do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 4, 16'h00FF);
    @(posedge clk);
    #1;
`ifdef REGWR_BYPASS_EN
    chk("byp_wr_en", wr_en, 1);
    chk("byp_wr_addr", wr_addr, 4);
    chk("byp_pending", pending, 0);
`else
    chk("nobyp_wr_en0", wr_en, 0);
    chk("nobyp_pending", pending, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("nobyp_wr_en1", wr_en, 1);
    chk("nobyp_wr_addr", wr_addr, 4);
    chk("nobyp_wr_data", wr_data, 16'h00FF);
`endif

    // Randomised traffic against a queue-based model
    do_reset();
    begin
      int            wt;
      bit            known;
      bit            e_en;
      bit            e_sel;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      mq.delete();
      wt     = 0;
      known  = 1;
      e_addr = '0;
      e_data = '0;
      for (int c = 0; c < 400; c++) begin
        logic [AW-1:0] pa;
        bit hit, frc, pr, mr, popd, byp, g;
        ent_t ge;
        int sz0;
        @(negedge clk);
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 1),
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              DW'($urandom), $urandom_range(0, 1),
              AW'($urandom_range(0, 3)), DW'($urandom));
        #1;
        pa  = p_regdst ? p_rd : p_rt;
        sz0 = mq.size();
        hit = 0;
        foreach (mq[k]) if (mq[k].a == pa) hit = 1;
        hit = hit && p_valid && (pa != 0);
        frc = (wt == LIM) && (sz0 != 0);
        pr  = !hit && !frc;
        mr  = (sz0 != DEPTH);
        chk($sformatf("rnd%0d_p_ready", c), p_ready, pr);
        chk($sformatf("rnd%0d_m_ready", c), m_ready, mr);
        chk($sformatf("rnd%0d_pending", c), pending, sz0);
        popd  = 0;
        byp   = 0;
        g     = 1;
        e_sel = 0;
        if (p_valid && pr) begin
          ge    = '{pa, p_data};
          e_sel = p_regdst;
        end else if (sz0 != 0) begin
          ge   = mq.pop_front();
          popd = 1;
        end else if (BYP && m_valid) begin
          ge  = '{m_addr, m_data};
          byp = 1;
        end else begin
          g  = 0;
          ge = '{AW'(0), DW'(0)};
        end
        if (m_valid && mr && !byp) mq.push_back('{m_addr, m_data});
        if (sz0 == 0 || popd) wt = 0;
        else if (wt < LIM) wt++;
        e_en = g && (ge.a != 0);
        if (g) begin
          known  = (ge.a != 0);
          e_addr = ge.a;
          e_data = ge.d;
        end
        @(posedge clk);
        #1;
        chk($sformatf("rnd%0d_wr_en", c), wr_en, e_en);
        chk($sformatf("rnd%0d_addr_sel", c), addr_sel, e_sel);
        if (known) begin
          chk($sformatf("rnd%0d_wr_addr", c), wr_addr, e_addr);
          chk($sformatf("rnd%0d_wr_data", c), wr_data, e_data);
        end
      end
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Sequences and shares the single register-file write port (5-bit address, 16-bit data) of the 16-bit MIPS datapath between two requesters.
- Requester P is the primary writeback path. Its destination is rt or rd, chosen by RegDst.
- Requester M is a late-result unit (multi-cycle mult/div) that buffers results in a small FIFO.
- The block drives the write enable, address and data, plus the RegDst select for the write-address mux. It enforces write-after-write ordering and bounds starvation.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 5, register address width.
- DEPTH, 2, M-side FIFO entries (power of two, >=2).
- STARVE_LIM, 4, max cycles a non-empty FIFO may wait before it is forced a grant.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- p_valid  in  1  primary writeback request.
- p_regdst  in  1  1: destination = p_rd, 0: destination = p_rt.
- p_rt  in  ADDR_W  rt field.
- p_rd  in  ADDR_W  rd field.
- p_data  in  DATA_W  primary write data.
- p_ready  out  1  primary accepted this cycle when p_valid&p_ready (combinational).
- m_valid  in  1  late-result request.
- m_addr  in  ADDR_W  late-result destination.
- m_data  in  DATA_W  late-result data.
- m_ready  out  1  FIFO can accept (combinational).
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  ADDR_W  write address (registered).
- wr_data  out  DATA_W  write data (registered).
- addr_sel  out  1  RegDst select to the address mux, = p_regdst of granted P, else 0 (registered).
- pending  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, any time): FIFO emptied (pending=0), wait counter=0, wr_en=0, wr_addr=0, wr_data=0, addr_sel=0. Entries in flight are discarded. Outputs are stable on the first edge after deassert.
- p_addr = p_regdst ? p_rd : p_rt.
- conflict = p_valid & (p_addr != 0) & (p_addr matches the address of any valid FIFO entry).
- force = (wait_cnt == STARVE_LIM) & (pending != 0).
- p_ready = !conflict & !force.
- m_ready = (pending != DEPTH). There is no same-cycle enqueue-through-full. A dequeue does not free space for an enqueue in the same cycle.
- Grant per cycle, one write max:
  - If p_valid & p_ready, grant P.
  - Else, if pending != 0, grant the FIFO head and pop it.
  - Else, idle.
- Latency: a grant decided in cycle N appears on wr_* during cycle N+1. P therefore has 1-cycle latency. M has at least 2 cycles: it is enqueued at edge N and drains at edge N+1 at the earliest.
- Address 0: the grant is consumed and the FIFO is popped if applicable, but wr_en=0. $0 is never written.
- Idle cycle: wr_en=0. wr_addr and wr_data hold their previous values. addr_sel=0.
- wait_cnt:
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise increments each cycle while pending != 0, saturating at STARVE_LIM.
- Simultaneous P grant and M enqueue: both occur. pending increments.
- Simultaneous FIFO pop and M enqueue (not full at cycle start): pending is unchanged. Pointers wrap modulo DEPTH.
- WAW ordering: a P write to an address still buffered in the FIFO stalls until that entry drains. The older M result therefore never overwrites a newer P result.

Optional Feature:
- Macro REGWR_BYPASS_EN.
- When defined: if pending == 0, P not granted (p_valid=0 or stalled) and m_valid=1, the M request is granted directly to wr_* at the next edge without entering the FIFO. M latency is 1 cycle and pending stays 0.
- When undefined: every M request goes through the FIFO (minimum 2 cycles).

Test Plan:
- Reset mid-burst: FIFO holds 2 entries, reset pulsed asynchronously between edges -> pending=0, wr_en=0, wr_addr=0, addr_sel=0 immediately; no stale write after deassert.
- P only: p_regdst=1, p_rd=7, p_rt=3, p_data=0x1234 -> next cycle wr_en=1, wr_addr=7, wr_data=0x1234, addr_sel=1. Repeat with p_regdst=0 -> wr_addr=3, addr_sel=0.
- Contention and starvation (STARVE_LIM=4): M enqueues addr 9 / 0xBEEF while P requests addr 5 every cycle:
  - P granted 4 cycles.
  - p_ready=0 on the 5th cycle and wr_addr=9 with 0xBEEF the following cycle.
  - wait_cnt then clears.
- WAW: FIFO holds addr 12 / 0x0AAA, P requests addr 12 / 0x0BBB -> p_ready=0 until the FIFO write of 0x0AAA, then 0x0BBB written next; final order 0x0AAA then 0x0BBB.
- Full FIFO and $0:
  - M pushes 3 back-to-back with P busy -> m_ready=0 after 2, pending=2.
  - P addr 0 granted -> wr_en stays 0.
- Bypass (REGWR_BYPASS_EN defined): empty FIFO, p_valid=0, M addr 4 / 0x00FF -> wr_en=1, wr_addr=4 next cycle, pending stays 0. Undefined -> write occurs one cycle later.
